// File: rtl/fma16_sched.sv
// Round-robin scheduler sharing one combinational fma16 datapath among NREQ requesters.
// Each accepted op holds the fma16 inputs for LAT cycles, then returns the tagged result.
module fma16_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic                 fma_mul,
    output logic                 fma_add,
    output logic                 fma_negr,
    output logic                 fma_negz,
    output logic [1:0]           fma_rm,
    input  logic [15:0]          fma_result,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Opcode to {mul, add, negr, negz}; negr negates the whole result, negz negates z.
    function automatic logic [3:0] decode_op(input logic [2:0] op);
        logic [3:0] ctl;
        case (op)
            3'b000:  ctl = 4'b0100;
            3'b001:  ctl = 4'b0101;
            3'b010:  ctl = 4'b1000;
            3'b011:  ctl = 4'b1100;
            3'b100:  ctl = 4'b1101;
            3'b101:  ctl = 4'b1110;
            3'b110:  ctl = 4'b1111;
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [3:0]      ctl_q, ctl_d;
    logic [1:0]      rm_q, rm_d;

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  gidx_s;
    logic [IDW-1:0]  idx_s;
    logic            found_s;
    logic [2:0]      op_s;

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                gidx_s         = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign op_s = req_op[int'(gidx_s)*3 +: 3];

    // Next-state logic for the IDLE/EXEC/RESP sequencer and its payload registers.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        ctl_d        = ctl_q;
        rm_d         = rm_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    id_d  = gidx_s;
                    ptr_d = (gidx_s == IDW'(NREQ - 1)) ? '0 : gidx_s + 1'b1;
                    if (op_s == OP_ILL) begin
                        // Illegal ops bypass the datapath; fma_* keep their previous values.
                        state_d      = S_RESP;
                        rsp_id_d     = gidx_s;
                        rsp_result_d = 16'h7E00;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = 4'(LAT - 1);
                        x_d     = req_x[{gidx_s, 4'b0000} +: 16];
                        y_d     = req_y[{gidx_s, 4'b0000} +: 16];
                        z_d     = req_z[{gidx_s, 4'b0000} +: 16];
                        rm_d    = req_rm[{gidx_s, 1'b0} +: 2];
                        ctl_d   = decode_op(op_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    rsp_id_d     = id_q;
                    rsp_result_d = fma_result;
                    rsp_err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= 4'd0;
            id_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= 16'h0000;
            rsp_err_q    <= 1'b0;
            x_q          <= 16'h0000;
            y_q          <= 16'h0000;
            z_q          <= 16'h0000;
            ctl_q        <= 4'b0000;
            rm_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            ctl_q        <= ctl_d;
            rm_q         <= rm_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) ? grant_s : '0;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign fma_x      = x_q;
    assign fma_y      = y_q;
    assign fma_z      = z_q;
    assign fma_mul    = ctl_q[3];
    assign fma_add    = ctl_q[2];
    assign fma_negr   = ctl_q[1];
    assign fma_negz   = ctl_q[0];
    assign fma_rm     = rm_q;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched with a small exact-value fma16 model on fma_result.
module tb_fma16_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [3*NREQ-1:0]  req_op;
    logic [16*NREQ-1:0] req_x, req_y, req_z;
    logic [2*NREQ-1:0]  req_rm;
    logic rsp_valid, rsp_ready, rsp_err, busy;
    logic [IDW-1:0] rsp_id;
    logic [15:0] rsp_result, fma_x, fma_y, fma_z, fma_result;
    logic fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0] fma_rm;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fma16_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_rm(fma_rm), .fma_result(fma_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real h2r(input logic [15:0] h);
        real mag;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            mag = real'(h[9:0]) / 16777216.0;
        end else begin
            mag = 1.0 + real'(h[9:0]) / 1024.0;
            for (int i = 0; i < e - 15; i++) mag = mag * 2.0;
            for (int i = 0; i < 15 - e; i++) mag = mag / 2.0;
        end
        return h[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        logic s;
        real  a;
        int   e, m;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 15;
        for (int i = 0; i < 30 && a >= 2.0; i++) begin a = a / 2.0; e++; end
        for (int i = 0; i < 30 && a < 1.0; i++) begin a = a * 2.0; e--; end
        m = $rtoi((a - 1.0) * 1024.0 + 0.5);
        return {s, e[4:0], m[9:0]};
    endfunction

    // fma16 reference: (mul ? x*y : x) + (add ? +/-z : 0), optionally negated.
    always_comb begin
        real p, zz, r;
        p  = fma_mul ? h2r(fma_x) * h2r(fma_y) : h2r(fma_x);
        zz = fma_add ? (fma_negz ? -h2r(fma_z) : h2r(fma_z)) : 0.0;
        r  = p + zz;
        fma_result = r2h(fma_negr ? -r : r);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z, input logic [1:0] rm);
        req_op[3*i +: 3]  = op;
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_z[16*i +: 16] = z;
        req_rm[2*i +: 2]  = rm;
    endtask

    task automatic accept(input int i, input string tag);
        int n;
        req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin tick(); n++; end
        check({tag, "_grant"}, 32'(req_ready), 32'(1) << i);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic collect(input string tag, input int lat, input int id,
                           input logic [15:0] res, input logic err);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_res"}, 32'(rsp_result), 32'(res));
        check({tag, "_err"}, 32'(rsp_err), 32'(err));
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  ctl;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[7];
    logic [47:0] prev_ops;
    logic [5:0]  prev_ctl;
    int order[6];
    int when[6];
    int na, idx;

    initial begin
        vecs[0] = '{3'b000, 4'b0100, 16'h4000};
        vecs[1] = '{3'b001, 4'b0101, 16'h0000};
        vecs[2] = '{3'b010, 4'b1000, 16'h4000};
        vecs[3] = '{3'b011, 4'b1100, 16'h4200};
        vecs[4] = '{3'b100, 4'b1101, 16'h3C00};
        vecs[5] = '{3'b101, 4'b1110, 16'hC200};
        vecs[6] = '{3'b110, 4'b1111, 16'hBC00};

        reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_rm = '0;
        tick(); tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_no_grant", 32'(req_ready), 32'd0);
        check("idle_fma_x", 32'(fma_x), 32'd0);

        // Single fmul from requester 0.
        set_req(0, 3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b00);
        accept(0, "mul");
        check("mul_ctl", 32'({fma_mul, fma_add, fma_negr, fma_negz}), 32'h8);
        check("mul_busy", 32'(busy), 32'd1);
        collect("mul", LAT, 0, 16'h4600, 1'b0);
        handshake("mul");

        // Decode sweep from requester 2.
        for (int k = 0; k < 7; k++) begin
            set_req(2, vecs[k].op, 16'h3C00, 16'h4000, 16'h3C00, 2'b01);
            accept(2, $sformatf("dec%0d", k));
            check($sformatf("dec%0d_ctl", k), 32'({fma_mul, fma_add, fma_negr, fma_negz}),
                  32'(vecs[k].ctl));
            check($sformatf("dec%0d_rm", k), 32'(fma_rm), 32'd1);
            collect($sformatf("dec%0d", k), LAT, 2, vecs[k].res, 1'b0);
            handshake($sformatf("dec%0d", k));
        end

        // Illegal opcode from requester 1.
        prev_ops = {fma_x, fma_y, fma_z};
        prev_ctl = {fma_mul, fma_add, fma_negr, fma_negz, fma_rm};
        set_req(1, 3'b111, 16'h1234, 16'h5678, 16'h9ABC, 2'b10);
        accept(1, "ill");
        check("ill_ops_hold", 32'({fma_x, fma_y} ^ prev_ops[47:16]), 32'd0);
        check("ill_z_hold", 32'(fma_z), 32'(prev_ops[15:0]));
        check("ill_ctl_hold", 32'({fma_mul, fma_add, fma_negr, fma_negz, fma_rm}), 32'(prev_ctl));
        collect("ill", 0, 1, 16'h7E00, 1'b1);
        handshake("ill");
        req_valid = 4'b1111;
        #1;
        check("ill_ptr", 32'(req_ready), 32'h4);
        req_valid = '0;
        #1;

        // Backpressure on a fadd from requester 3.
        set_req(3, 3'b000, 16'h3C00, 16'h0000, 16'h3C00, 2'b00);
        accept(3, "bp");
        collect("bp", LAT, 3, 16'h4000, 1'b0);
        set_req(0, 3'b010, 16'h4000, 16'h4000, 16'h0000, 2'b00);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp%0d_hold", k), 32'({rsp_valid, busy, rsp_id, rsp_result, req_ready}),
                  32'({1'b1, 1'b1, 2'd3, 16'h4000, 4'b0000}));
        end
        handshake("bp");
        check("bp_next_grant", 32'(req_ready), 32'h1);
        tick();
        check("bp_next_accept", 32'({busy, fma_mul}), 32'h3);

        // Reset one cycle after that accept.
        tick();
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        check("mid_rst_outs", 32'({rsp_valid, busy, rsp_err, rsp_id, fma_mul, fma_add, fma_rm}), 32'd0);
        check("mid_rst_res", 32'(rsp_result), 32'd0);
        check("mid_rst_fma", 32'(fma_x | fma_y), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst%0d_norsp", k), 32'({rsp_valid, busy}), 32'd0);
        end
        req_valid = 4'b1110;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h2);
        req_valid = '0;
        #1;

        // Round robin with every requester asking.
        for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, 16'h3C00, 16'h0000, 16'h3C00, 2'b00);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        na = 0;
        for (int n = 0; n < 100 && na < 6; n++) begin
            if (|req_ready) begin
                idx = 0;
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
                order[na] = idx;
                when[na]  = cyc;
                na++;
            end
            tick();
        end
        check("rr_count", 32'(na), 32'd6);
        for (int k = 0; k < na; k++) begin
            check($sformatf("rr%0d_id", k), 32'(order[k]), 32'(k % NREQ));
            if (k > 0) check($sformatf("rr%0d_gap", k), 32'(when[k] - when[k-1]), 32'(LAT + 2));
        end
        req_valid = '0;
        for (int n = 0; n < 20 && busy; n++) tick();
        check("rr_drain", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
